md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL provide parameter MUL_CYCLES, default 5, meaning busy duration of mult/multu in cycles.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, meaning busy duration of div/divu in cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port md_func, input, 3, EX-stage operation: 0 none, 1 mthi, 2 mtlo, 3 mul, 4 div; codes 5-7 are treated as none.
REQ-006 SHALL have port md_sign, input, 1, 1 = signed (mult/div), 0 = unsigned (multu/divu).
REQ-007 SHALL have port op_a, input, 32, rs operand (dividend/multiplicand, mthi/mtlo data).
REQ-008 SHALL have port op_b, input, 32, rt operand (divisor/multiplier).
REQ-009 SHALL have port hi, output, 32, architected HI register.
REQ-010 SHALL have port lo, output, 32, architected LO register.
REQ-011 SHALL have port busy, output, 1, registered: an operation is in flight.
REQ-012 SHALL have port md_stall_req, output, 1, combinational busy OR (md_func is 3 or 4); consumed by the hazard unit.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV with a down-counter cnt.
REQ-014 In IDLE, md_func=3 SHALL latch the 64-bit product into pending registers, load cnt=MUL_CYCLES-1, and enter MUL.
REQ-015 In IDLE, md_func=4 SHALL latch the quotient and remainder into pending registers, load cnt=DIV_CYCLES-1, and enter DIV.
REQ-016 busy SHALL be 1 from the cycle after start for exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-017 In MUL or DIV with cnt=0, the FSM SHALL commit pending values to hi/lo on that edge and return to IDLE; hi/lo are visible in the first cycle after busy falls.
REQ-018 In MUL or DIV with cnt≠0, the FSM SHALL decrement cnt; hi/lo SHALL hold their old values until commit.
REQ-019 Product SHALL be the full 64-bit signed or unsigned result; hi = bits 63:32, lo = bits 31:0.
REQ-020 Division SHALL give lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-022 Divisor zero SHALL still run the full DIV_CYCLES busy period, and hi/lo SHALL remain unchanged at commit.
REQ-023 In IDLE, mthi (1) SHALL write hi=op_a and mtlo (2) SHALL write lo=op_a on the same edge; the value is readable the next cycle.
REQ-024 While busy=1, any md_func (1-4) SHALL be ignored; the hazard unit guarantees no such issue, and the bench asserts this.
REQ-025 hi and lo SHALL be directly register outputs; no bypass of pending values.

Reset
REQ-026 On reset=1 at a clock edge: state=IDLE, cnt=0, hi=0, lo=0, pending registers=0, busy=0; this overrides any input including a start in the same cycle.
REQ-027 Reset mid-operation SHALL abort without commit; the next cycle shows busy=0 and hi=lo=0.

Structure
REQ-028 The md_func encoding SHALL be defined as named constants (MD_NONE, MD_MTHI, MD_MTLO, MD_MUL, MD_DIV) in the shared control struct-definition package, used by both the controller and md_unit.
REQ-029 The FSM state enum SHALL be local to md_unit.
REQ-030 No sub-module SHALL be used; multiply and divide are behavioural operators inside md_unit.

Verification
REQ-031 Scenario: md_func=3, md_sign=1, op_a=0xFFFFFFFF, op_b=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 Scenario: the same operands with md_sign=0 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-033 Scenario: md_func=4, md_sign=1, op_a=0xFFFFFFF9 (-7), op_b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 Scenario: with hi=0x11, lo=0x22, run divu by 0 -> busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
REQ-035 Scenario: mthi with op_a=0x12345678 -> hi=0x12345678 next cycle; mtlo issued while busy -> lo unchanged.
REQ-036 Scenario: reset asserted in the 3rd busy cycle of a div -> next cycle busy=0, hi=lo=0, and md_stall_req=0 with md_func=0.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared control definitions: md_func operation encoding and the HI/LO result pair.
package md_unit_pkg;

  localparam logic [2:0] MD_NONE = 3'd0;
  localparam logic [2:0] MD_MTHI = 3'd1;
  localparam logic [2:0] MD_MTLO = 3'd2;
  localparam logic [2:0] MD_MUL  = 3'd3;
  localparam logic [2:0] MD_DIV  = 3'd4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architected HI/LO; results commit MUL_CYCLES/DIV_CYCLES after start.
// No handshake: md_stall_req holds the pipeline while busy or while a mul/div sits in EX.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_func,
  input  logic        md_sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall_req
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [CNT_W-1:0] cnt;
  hilo_t       pend;

  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, uquo, urem, quo, rem;
  hilo_t       div_res;

  // Sign-extending to 64 bits makes one truncated multiply serve both signed and unsigned.
  assign ext_a = {{32{md_sign & op_a[31]}}, op_a};
  assign ext_b = {{32{md_sign & op_b[31]}}, op_b};
  assign prod  = ext_a * ext_b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign neg_a = md_sign & op_a[31];
  assign neg_b = md_sign & op_b[31];
  assign mag_a = neg_a ? (32'd0 - op_a) : op_a;
  assign mag_b = neg_b ? (32'd0 - op_b) : op_b;
  assign uquo  = mag_a / mag_b;
  assign urem  = mag_a % mag_b;
  assign quo   = (neg_a ^ neg_b) ? (32'd0 - uquo) : uquo;
  assign rem   = neg_a ? (32'd0 - urem) : urem;
  assign div_res = '{hi: rem, lo: quo};

  assign md_stall_req = busy | (md_func == MD_MUL) | (md_func == MD_DIV);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      pend  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (md_func)
            MD_NONE: ;
            MD_MTHI: hi <= op_a;
            MD_MTLO: lo <= op_a;
            MD_MUL: begin
              pend  <= prod;
              cnt   <= CNT_W'(MUL_CYCLES - 1);
              busy  <= 1'b1;
              state <= MUL;
            end
            MD_DIV: begin
              // HI/LO cannot change while busy, so a divide by zero re-commits the current values.
              pend  <= (op_b == 32'd0) ? '{hi: hi, lo: lo} : div_res;
              cnt   <= CNT_W'(DIV_CYCLES - 1);
              busy  <= 1'b1;
              state <= DIV;
            end
            default: ;
          endcase
        end
        MUL, DIV: begin
          if (cnt == '0) begin
            hi    <= pend.hi;
            lo    <= pend.lo;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
